// File: rtl/dvi_stim_pkg.sv
// Shared types and default 640x480@60 timing for the DVI stimulus generator.
// Build option: define DVI_STIM_STOP_EN to allow stopping at frame boundaries.
package dvi_stim_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dvi_state_t;

    localparam int DVI_H_ACTIVE = 640;
    localparam int DVI_H_FP     = 16;
    localparam int DVI_H_SYNC   = 96;
    localparam int DVI_H_BP     = 48;

    localparam int DVI_V_ACTIVE = 480;
    localparam int DVI_V_FP     = 10;
    localparam int DVI_V_SYNC   = 2;
    localparam int DVI_V_BP     = 33;

    localparam logic DVI_SYNC_ACTIVE = 1'b0;

endpackage

// File: rtl/dvi_axis_counter.sv
// One timing axis (horizontal or vertical): a wrapping position counter plus
// combinational decodes of the active and sync regions for that position.
module dvi_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    localparam int TOTAL = ACTIVE + FP + SYNC + BP,
    localparam int W     = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
    input  logic         clock,
    input  logic         enable,
    input  logic         clear,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    // One spare bit so a sync region ending exactly at TOTAL still compares correctly.
    logic [W:0] cnt_ext;

    assign cnt_ext = {1'b0, count};
    assign wrap    = (cnt_ext == (W+1)'(TOTAL - 1));
    assign active  = (cnt_ext < (W+1)'(ACTIVE));
    assign sync    = (cnt_ext >= (W+1)'(ACTIVE + FP)) &&
                     (cnt_ext <  (W+1)'(ACTIVE + FP + SYNC));

    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/dvi_stimulate.sv
// Free-running DVI/VGA timing generator: hsync, vsync and ve, one pixel per clock.
// Build option: define DVI_STIM_STOP_EN to re-sample start at the end of each frame.
module dvi_stimulate
    import dvi_stim_pkg::*;
#(
    parameter int   H_ACTIVE    = DVI_H_ACTIVE,
    parameter int   H_FP        = DVI_H_FP,
    parameter int   H_SYNC      = DVI_H_SYNC,
    parameter int   H_BP        = DVI_H_BP,
    parameter int   V_ACTIVE    = DVI_V_ACTIVE,
    parameter int   V_FP        = DVI_V_FP,
    parameter int   V_SYNC      = DVI_V_SYNC,
    parameter int   V_BP        = DVI_V_BP,
    parameter logic SYNC_ACTIVE = DVI_SYNC_ACTIVE
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic hsync_out,
    output logic vsync_out,
    output logic ve
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    dvi_state_t    state;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap, h_active, h_sync;
    logic          v_wrap, v_active, v_sync;
    logic          running, clear_cnt;
    logic          unused_debug;

    // Counters sit at (0,0) whenever idle so RUN always begins at the top-left pixel.
    assign running   = (state == RUN);
    assign clear_cnt = reset || !running;

    dvi_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clock  (clock),
        .enable (running),
        .clear  (clear_cnt),
        .count  (h_cnt),
        .wrap   (h_wrap),
        .active (h_active),
        .sync   (h_sync)
    );

    dvi_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clock  (clock),
        .enable (running && h_wrap),
        .clear  (clear_cnt),
        .count  (v_cnt),
        .wrap   (v_wrap),
        .active (v_active),
        .sync   (v_sync)
    );

    // Raw counts are only of interest on waveforms.
    assign unused_debug = ^{h_cnt, v_cnt, v_wrap};

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ve        <= 1'b0;
            hsync_out <= ~SYNC_ACTIVE;
            vsync_out <= ~SYNC_ACTIVE;
        end else begin
            case (state)
                IDLE: begin
                    ve        <= 1'b0;
                    hsync_out <= ~SYNC_ACTIVE;
                    vsync_out <= ~SYNC_ACTIVE;
                    if (start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    ve        <= h_active && v_active;
                    hsync_out <= h_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                    vsync_out <= v_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
`ifdef DVI_STIM_STOP_EN
                    if (h_wrap && v_wrap && !start) begin
                        state <= IDLE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dvi_stimulate.sv
// Self-checking bench for dvi_stimulate using a shrunken timing (16 x 12 total)
// so several full frames fit in a short run.
module tb_dvi_stimulate;

    localparam int   HA = 8;
    localparam int   HF = 2;
    localparam int   HS = 3;
    localparam int   HB = 3;
    localparam int   VA = 5;
    localparam int   VF = 2;
    localparam int   VS = 2;
    localparam int   VB = 3;
    localparam logic SA = 1'b0;
    localparam int   HT    = HA + HF + HS + HB;
    localparam int   VT    = VA + VF + VS + VB;
    localparam int   FRAME = HT * VT;
`ifdef DVI_STIM_STOP_EN
    localparam bit   STOP = 1'b1;
`else
    localparam bit   STOP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    logic start;
    logic hsync_out, vsync_out, ve;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: whether timing runs, and the linear pixel index to emit next.
    bit mrun = 1'b0;
    int mpos = 0;

    typedef struct {
        logic rst;
        logic st;
        int   len;
        logic e_ve;
        logic e_hs;
        logic e_vs;
    } seg_t;

    seg_t tbl[10];

    dvi_stimulate #(
        .H_ACTIVE    (HA),
        .H_FP        (HF),
        .H_SYNC      (HS),
        .H_BP        (HB),
        .V_ACTIVE    (VA),
        .V_FP        (VF),
        .V_SYNC      (VS),
        .V_BP        (VB),
        .SYNC_ACTIVE (SA)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .ve        (ve)
    );

    always #5 clock = ~clock;

    function automatic logic [2:0] decode(input int pos);
        int line;
        int px;
        logic [2:0] r;
        line = pos / HT;
        px   = pos % HT;
        r[2] = (px < HA) && (line < VA);
        r[1] = (px >= HA + HF && px < HA + HF + HS) ? SA : ~SA;
        r[0] = (line >= VA + VF && line < VA + VF + VS) ? SA : ~SA;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic e_ve, input logic e_hs, input logic e_vs);
        n_checks++;
        if ({ve, hsync_out, vsync_out} === {e_ve, e_hs, e_vs}) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s at %0t: ve/hs/vs got %b%b%b, expected %b%b%b",
                     name, $time, ve, hsync_out, vsync_out, e_ve, e_hs, e_vs);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Drive one clock of inputs, advance the model, and compare after the edge.
    task automatic applyStimulus(input logic r, input logic s);
        logic [2:0] e;
        reset = r;
        start = s;
        if (r) begin
            e    = {1'b0, ~SA, ~SA};
            mrun = 1'b0;
            mpos = 0;
        end else if (!mrun) begin
            e = {1'b0, ~SA, ~SA};
            if (s) begin
                mrun = 1'b1;
                mpos = 0;
            end
        end else begin
            e = decode(mpos);
            if (STOP && mpos == FRAME - 1 && !s) begin
                mrun = 1'b0;
            end
            mpos = (mpos + 1) % FRAME;
        end
        @(posedge clock);
        #1;
        checkOutput("model", e[2], e[1], e[0]);
    endtask

    initial begin
        int first_ve, hs_fall1, hs_fall2, vs_fall1, vs_fall2, vs_width, ve_count;
        logic p_hs, p_vs, p_ve;

        reset = 1'b1;
        start = 1'b0;

        tbl[0] = '{1'b1, 1'b0, 5, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 8, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 3, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 8, 1'b1, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b1};

        $display("[TB] directed table: reset, start latency, first lines");
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < tbl[i].len; c++) begin
                applyStimulus(tbl[i].rst, tbl[i].st);
                checkOutput($sformatf("table[%0d]", i), tbl[i].e_ve, tbl[i].e_hs, tbl[i].e_vs);
            end
        end

        $display("[TB] mid-frame reset");
        for (int i = 0; i < 2 * FRAME && mpos != 3 * HT + 5; i++) begin
            applyStimulus(1'b0, 1'b1);
        end
        checkValue("reach_mid_frame", mpos, 3 * HT + 5);
        checkOutput("pre_reset_active", 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("mid_reset", 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("idle_after_reset", 1'b0, 1'b1, 1'b1);

        $display("[TB] restart and measure sync timing");
        first_ve = -1; hs_fall1 = -1; hs_fall2 = -1;
        vs_fall1 = -1; vs_fall2 = -1; vs_width = -1; ve_count = 0;
        p_ve = 1'b0; p_hs = 1'b1; p_vs = 1'b1;
        applyStimulus(1'b0, 1'b1);
        for (int k = 1; k <= 320; k++) begin
            applyStimulus(1'b0, 1'b1);
            if (k <= FRAME && ve) ve_count++;
            if (ve && !p_ve && first_ve < 0) first_ve = k;
            if (!hsync_out && p_hs) begin
                if (hs_fall1 < 0) hs_fall1 = k;
                else if (hs_fall2 < 0) hs_fall2 = k;
            end
            if (!vsync_out && p_vs) begin
                if (vs_fall1 < 0) vs_fall1 = k;
                else if (vs_fall2 < 0) vs_fall2 = k;
            end
            if (vsync_out && !p_vs && vs_width < 0 && vs_fall1 >= 0) vs_width = k - vs_fall1;
            p_ve = ve; p_hs = hsync_out; p_vs = vsync_out;
        end
        checkValue("first_ve_rise", first_ve, 1);
        checkValue("hsync_first_fall", hs_fall1, 11);
        checkValue("line_period", hs_fall2 - hs_fall1, HT);
        checkValue("vsync_first_fall", vs_fall1, 113);
        checkValue("vsync_width", vs_width, 32);
        checkValue("frame_period", vs_fall2 - vs_fall1, FRAME);
        checkValue("ve_per_frame", ve_count, 40);

        $display("[TB] randomized run against reference model");
        for (int i = 0; i < 2500; i++) begin
            applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("[TB] start dropped mid-frame");
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < FRAME; i++) applyStimulus(1'b0, 1'b0);
        ve_count = 0;
        for (int i = 0; i < FRAME; i++) begin
            applyStimulus(1'b0, 1'b0);
            if (ve) ve_count++;
        end
        checkValue("ve_after_start_drop", ve_count, STOP ? 0 : 40);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
